gc_apb_slot_ctrl: RTL
=====================

# gc_apb_slot_ctrl

Fabric-side APB3 controller between the MSS APB master port (MSSP*) and up to four fabric peripheral slots: controller interface, rumble driver and similar. It decodes each MSS transfer to one slot, re-times the SETUP/ACCESS phases onto a registered slave bus and returns the slot response. It generates an error response for unmapped slots and, optionally, for stalled slaves. It also keeps a saturating error count for firmware debug.

## Interface
- NSLOTS, 4: number of slave slots (1..4).
- SLOT_AW, 8: per-slot address width; slot index = MSSPADDR[SLOT_AW+1:SLOT_AW].
- SLOT_MASK, 4'b1111: bit i set = slot i populated.
- TIMEOUT, 255: maximum ACCESS-phase wait cycles, 1..65535.
- FAB_CLK  in  1  fabric clock; all logic on rising edge.
- M2F_RESET_N  in  1  synchronous, active-low reset.
- MSSPSEL, MSSPENABLE, MSSPWRITE  in  1  MSS APB master control.
- MSSPADDR  in  32  MSS address; bits above SLOT_AW+1 ignored.
- MSSPWDATA  in  32  write data.
- MSSPRDATA  out  32  read data, valid only while MSSPREADY=1.
- MSSPREADY  out  1  transfer complete, one-cycle pulse.
- MSSPSLVERR  out  1  error, qualified by MSSPREADY.
- S_PSEL  out  NSLOTS  one-hot slot select.
- S_PENABLE, S_PWRITE  out  1  slave bus control.
- S_PADDR  out  SLOT_AW  in-slot address.
- S_PWDATA  out  32  slave write data.
- S_PRDATA  in  NSLOTS*32  slot i at [32i+31:32i].
- S_PREADY, S_PSLVERR  in  NSLOTS  per-slot response.
- err_count  out  8  saturating error-response counter.
- err_addr  out  32  MSSPADDR of the most recent error response.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP, ERR. All outputs are registered.
- IDLE: on MSSPSEL=1 and MSSPENABLE=0, latch addr, write and wdata, then compute slot.
  - Slot ≥ NSLOTS or SLOT_MASK bit clear -> ERR.
  - Otherwise -> SETUP.
- SETUP: S_PSEL[slot]=1, S_PENABLE=0 for one cycle -> ACCESS.
- ACCESS: S_PSEL[slot]=1, S_PENABLE=1, held stable.
  - On S_PREADY[slot]=1: capture S_PRDATA slice (reads) or 0 (writes), capture S_PSLVERR[slot] -> RESP.
- RESP: MSSPREADY=1 with captured data and error for one cycle -> IDLE. The next cycle deasserts S_PSEL and S_PENABLE.
- ERR: MSSPREADY=1, MSSPSLVERR=1, MSSPRDATA=0 for one cycle -> IDLE.
- err_count increments, saturating at 255, on every error response: ERR, or RESP with PSLVERR. err_addr loads in the same cycle.
- MSSPRDATA=0 and MSSPSLVERR=0 whenever MSSPREADY=0.
- Protocol violation (MSSPSEL drops mid-transfer): the slave transfer still completes, the response pulse is still issued, then IDLE. There is no hang.

## Timing
- Reset (M2F_RESET_N=0 at an edge): state=IDLE. Every output is 0: MSSPRDATA, MSSPREADY, MSSPSLVERR, S_PSEL, S_PENABLE, S_PWRITE, S_PADDR, S_PWDATA, err_count, err_addr. Reset mid-transfer abandons the transfer silently.
- Mapped, zero-wait slave: MSS SETUP at cycle 0, S_PSEL at cycle 1, S_PENABLE at cycle 2, MSSPREADY at cycle 3. That is 2 MSS wait states.
- Each slave wait state adds one cycle.
- Unmapped slot: MSSPREADY+MSSPSLVERR at cycle 1, zero MSS wait states.
- Back-to-back: a new SETUP is accepted in the IDLE cycle immediately following RESP or ERR.

## Configuration
- GC_APB_TIMEOUT_EN defined:
  - A counter clears on SETUP and increments each ACCESS cycle with S_PREADY[slot]=0.
  - If the count reaches TIMEOUT with the slave still not ready, S_PSEL and S_PENABLE deassert in the next cycle and the FSM goes to ERR. The MSS then sees PSLVERR and PRDATA=0.
  - S_PREADY in the same cycle the counter hits TIMEOUT wins (normal RESP).
- Undefined: no counter. ACCESS waits indefinitely.

## Structure
- Package gc_apb_pkg:
  - FSM state enum.
  - GC_APB_ERR_RDATA (32'h0).
  - Slot-index width constant.
  - Function slot_valid(idx, mask, nslots).
- Sub-module gc_apb_timeout: clear/enable/terminal-count counter, instantiated only under GC_APB_TIMEOUT_EN.

## Test plan
- Read slot 1, S_PRDATA slice=32'hCAFE_0001, zero wait -> MSSPREADY at cycle 3, MSSPRDATA=32'hCAFE_0001, SLVERR=0, err_count=0.
- Write 32'h1234_5678 to addr 0x1FC, slot 1 SLOT_AW=8 -> S_PSEL=4'b0010, S_PADDR=8'hFC, S_PWDATA=32'h1234_5678, S_PWRITE=1.
- SLOT_MASK=4'b0111, access slot 3 -> MSSPREADY+SLVERR at cycle 1, S_PSEL never asserts, err_count=1, err_addr=addr.
- Slot 0 returns PSLVERR after 5 waits -> MSSPREADY at cycle 8 with SLVERR=1. After 256 such errors, err_count stays 255.
- GC_APB_TIMEOUT_EN, TIMEOUT=16, slot 2 never ready -> S_PSEL drops after 16 ACCESS cycles, MSS sees SLVERR with PRDATA=0. The next transfer to slot 0 completes normally.
- Assert reset during ACCESS -> next cycle all outputs 0 and state IDLE. A fresh read after reset completes normally.

Source files
------------

// File: rtl/gc_apb_pkg.sv
// Shared types and constants for the fabric APB slot controller.
package gc_apb_pkg;

  localparam int unsigned MAX_SLOTS        = 4;
  localparam int unsigned SLOT_IW          = 2;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned ERRCNT_W         = 8;
  localparam logic [31:0] GC_APB_ERR_RDATA = 32'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP,
    ST_ERR
  } state_e;

  // A slot is usable only if it exists and is populated.
  function automatic logic slot_valid(input logic [SLOT_IW-1:0]   idx,
                                      input logic [MAX_SLOTS-1:0] mask,
                                      input int unsigned          nslots);
    return (32'(idx) < nslots) && mask[idx];
  endfunction

endpackage

// File: rtl/gc_apb_timeout.sv
// ACCESS-phase stall counter; tc_c flags the cycle in which the stall limit is reached.
module gc_apb_timeout #(
  parameter int unsigned MAX = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CW = 16;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counts completed stall cycles, so this stall is the MAX-th one.
  assign tc_c = en && (cnt_q == CW'(MAX - 1));

endmodule

// File: rtl/gc_apb_slot_ctrl.sv
// MSS APB3 to fabric slot bridge with registered slave bus and error reporting.
// Optional stalled-slave timeout enabled by defining GC_APB_TIMEOUT_EN.
module gc_apb_slot_ctrl
  import gc_apb_pkg::*;
#(
  parameter int unsigned          NSLOTS    = 4,
  parameter int unsigned          SLOT_AW   = 8,
  parameter logic [MAX_SLOTS-1:0] SLOT_MASK = 4'b1111,
  parameter int unsigned          TIMEOUT   = 255
) (
  input  logic                     FAB_CLK,
  input  logic                     M2F_RESET_N,
  input  logic                     MSSPSEL,
  input  logic                     MSSPENABLE,
  input  logic                     MSSPWRITE,
  input  logic [31:0]              MSSPADDR,
  input  logic [31:0]              MSSPWDATA,
  output logic [31:0]              MSSPRDATA,
  output logic                     MSSPREADY,
  output logic                     MSSPSLVERR,
  output logic [NSLOTS-1:0]        S_PSEL,
  output logic                     S_PENABLE,
  output logic                     S_PWRITE,
  output logic [SLOT_AW-1:0]       S_PADDR,
  output logic [31:0]              S_PWDATA,
  input  logic [NSLOTS*32-1:0]     S_PRDATA,
  input  logic [NSLOTS-1:0]        S_PREADY,
  input  logic [NSLOTS-1:0]        S_PSLVERR,
  output logic [7:0]               err_count,
  output logic [31:0]              err_addr
);

  localparam int unsigned PRW = MAX_SLOTS * DATA_W;

  if (NSLOTS < 1 || NSLOTS > MAX_SLOTS) begin : g_bad_nslots
    $error("NSLOTS must be 1..4");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT must be 1..65535");
  end

  state_e                state_q, state_d;
  logic [SLOT_IW-1:0]    slot_q, slot_d;
  logic [31:0]           addr_q, addr_d;
  logic                  pwrite_q, pwrite_d;
  logic [SLOT_AW-1:0]    paddr_q, paddr_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic [NSLOTS-1:0]     psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  mready_q, mready_d;
  logic                  mslverr_q, mslverr_d;
  logic [31:0]           mrdata_q, mrdata_d;
  logic [ERRCNT_W-1:0]   err_count_q, err_count_d;
  logic [31:0]           err_addr_q, err_addr_d;

  logic [SLOT_IW-1:0]    slot_idx_c;
  logic [MAX_SLOTS-1:0]  pready_all_c, pslverr_all_c;
  logic [PRW-1:0]        prdata_all_c;
  logic [31:0]           prdata_arr_c [MAX_SLOTS];
  logic                  to_tc_c;
  logic                  err_evt_c;
  logic [31:0]           err_at_c;

  // Widen slot response buses to the full slot-index range.
  assign slot_idx_c    = MSSPADDR[SLOT_AW+1:SLOT_AW];
  assign pready_all_c  = MAX_SLOTS'(S_PREADY);
  assign pslverr_all_c = MAX_SLOTS'(S_PSLVERR);
  assign prdata_all_c  = PRW'(S_PRDATA);

  always_comb begin
    for (int i = 0; i < MAX_SLOTS; i++) begin
      prdata_arr_c[i] = prdata_all_c[DATA_W*i +: DATA_W];
    end
  end

`ifdef GC_APB_TIMEOUT_EN
  gc_apb_timeout #(
    .MAX (TIMEOUT)
  ) u_timeout (
    .clk   (FAB_CLK),
    .rst_n (M2F_RESET_N),
    .clr   (state_q == ST_SETUP),
    .en    ((state_q == ST_ACCESS) && !pready_all_c[slot_q]),
    .tc_c  (to_tc_c)
  );
`else
  assign to_tc_c = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    addr_d      = addr_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    mready_d    = 1'b0;
    mslverr_d   = 1'b0;
    mrdata_d    = GC_APB_ERR_RDATA;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    err_evt_c   = 1'b0;
    err_at_c    = addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (MSSPSEL && !MSSPENABLE) begin
          addr_d = MSSPADDR;
          if (slot_valid(slot_idx_c, SLOT_MASK, NSLOTS)) begin
            slot_d    = slot_idx_c;
            pwrite_d  = MSSPWRITE;
            paddr_d   = MSSPADDR[SLOT_AW-1:0];
            pwdata_d  = MSSPWDATA;
            psel_d    = NSLOTS'(MAX_SLOTS'(1) << slot_idx_c);
            penable_d = 1'b0;
            state_d   = ST_SETUP;
          end else begin
            // Unmapped: answer immediately, slave bus untouched.
            mready_d  = 1'b1;
            mslverr_d = 1'b1;
            err_evt_c = 1'b1;
            err_at_c  = MSSPADDR;
            state_d   = ST_ERR;
          end
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready_all_c[slot_q]) begin
          mrdata_d  = pwrite_q ? GC_APB_ERR_RDATA : prdata_arr_c[slot_q];
          mslverr_d = pslverr_all_c[slot_q];
          mready_d  = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
          err_evt_c = pslverr_all_c[slot_q];
          state_d   = ST_RESP;
        end else if (to_tc_c) begin
          mready_d  = 1'b1;
          mslverr_d = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
          err_evt_c = 1'b1;
          state_d   = ST_ERR;
        end
      end
      ST_RESP, ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    if (err_evt_c) begin
      if (err_count_q != '1) begin
        err_count_d = err_count_q + ERRCNT_W'(1);
      end
      err_addr_d = err_at_c;
    end
  end

  always_ff @(posedge FAB_CLK) begin
    if (!M2F_RESET_N) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      addr_q      <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      mready_q    <= 1'b0;
      mslverr_q   <= 1'b0;
      mrdata_q    <= '0;
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      addr_q      <= addr_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      mready_q    <= mready_d;
      mslverr_q   <= mslverr_d;
      mrdata_q    <= mrdata_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign MSSPRDATA  = mrdata_q;
  assign MSSPREADY  = mready_q;
  assign MSSPSLVERR = mslverr_q;
  assign S_PSEL     = psel_q;
  assign S_PENABLE  = penable_q;
  assign S_PWRITE   = pwrite_q;
  assign S_PADDR    = paddr_q;
  assign S_PWDATA   = pwdata_q;
  assign err_count  = err_count_q;
  assign err_addr   = err_addr_q;

endmodule
